// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave with oversampled SCLK/SS_n/MOSI, one-entry TX holding register and RX word strobe.
// Latency: rx_valid SYNC_STAGES+2 clk after the final SCLK rise is sampled; MISO moves 3 clk after a sampled SCLK fall.
// Backpressure: tx_valid/tx_ready on the holding register; none on RX, rx_data is overwritten by the next word.
module spi_slave_responder #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_WORD   = '1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              spi_sclk,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_abort,
    output logic              busy
);
    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

    // Reset asserts asynchronously and releases on a clock edge.
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) rst_pipe <= '0;
        else                rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic sclk_s, ss_s, sclk_dly, ss_dly;
    logic sclk_rise_q, sclk_fall_q, mosi_q;
    logic ss_fall, ss_rise;

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign ss_s    = ss_sync[SYNC_STAGES-1];
    assign ss_fall = ~ss_s & ss_dly;
    assign ss_rise = ss_s & ~ss_dly;

    // SCLK edges are registered once more; mosi_q is captured alongside the rise flag.
    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync   <= '0;
            mosi_sync   <= '0;
            ss_sync     <= '1;
            sclk_dly    <= 1'b0;
            ss_dly      <= 1'b1;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            ss_sync     <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            sclk_dly    <= sclk_s;
            ss_dly      <= ss_s;
            sclk_rise_q <= sclk_s & ~sclk_dly;
            sclk_fall_q <= ~sclk_s & sclk_dly;
            mosi_q      <= mosi_sync[SYNC_STAGES-1];
        end
    end

    state_t            state;
    logic [DATA_W-1:0] hold_dat;
    logic              hold_full;
    logic [DATA_W-2:0] tx_shift;
    logic [DATA_W-2:0] rx_shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic              reload;
    logic              rx_pend;
    logic              tx_accept;
    logic              load_now;
    logic [DATA_W-1:0] load_word;

    assign tx_ready  = ~hold_full;
    assign tx_accept = tx_valid & ~hold_full;
    assign load_word = hold_full ? hold_dat : IDLE_WORD;
    assign load_now  = ~ss_rise & ((state == ST_LOAD) ||
                                   ((state == ST_SHIFT) && sclk_fall_q && reload));

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            hold_dat    <= '0;
            hold_full   <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            reload      <= 1'b0;
            rx_pend     <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_valid    <= rx_pend;
            rx_pend     <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
            busy        <= ~ss_s;
            spi_miso_oe <= ~ss_s;

            // A word accepted in the same cycle as an underrun load stays in the register.
            if (tx_accept) hold_dat <= tx_data;
            hold_full <= tx_accept | (hold_full & ~load_now);

            if (load_now) begin
                {spi_miso, tx_shift} <= load_word;
                tx_underrun          <= ~hold_full;
            end

            if (ss_rise) begin
                state       <= ST_IDLE;
                bit_cnt     <= '0;
                reload      <= 1'b0;
                frame_abort <= (bit_cnt != '0);
            end else begin
                case (state)
                    ST_IDLE: begin
                        bit_cnt <= '0;
                        reload  <= 1'b0;
                        if (ss_fall) state <= ST_LOAD;
                    end
                    ST_LOAD: state <= ST_SHIFT;
                    ST_SHIFT: begin
                        if (sclk_rise_q) begin
                            if (bit_cnt == LAST_BIT) begin
                                rx_data <= {rx_shift, mosi_q};
                                rx_pend <= 1'b1;
                                bit_cnt <= '0;
                                reload  <= 1'b1;
                            end else begin
                                rx_shift <= {rx_shift[DATA_W-3:0], mosi_q};
                                bit_cnt  <= bit_cnt + 1'b1;
                            end
                        end
                        if (sclk_fall_q) begin
                            if (reload) reload <= 1'b0;
                            else        {spi_miso, tx_shift} <= {tx_shift, 1'b0};
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed and randomized SPI master driving spi_slave_responder, checked against a word-level queue model.
module tb_spi_slave_responder;
    localparam int         DATA_W      = 8;
    localparam int         SYNC_STAGES = 2;
    localparam logic [7:0] IDLE_W      = 8'hFF;

    logic       clk_clk       = 1'b0;
    logic       reset_reset_n = 1'b1;
    logic       spi_sclk      = 1'b0;
    logic       spi_ss_n      = 1'b1;
    logic       spi_mosi      = 1'b0;
    logic [7:0] tx_data       = 8'h00;
    logic       tx_valid      = 1'b0;
    logic       spi_miso, spi_miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort, busy;
    logic [7:0] rx_data;

    spi_slave_responder #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .frame_abort(frame_abort), .busy(busy)
    );

    always #5 clk_clk = ~clk_clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0, last_rise_cyc = 0, last_rxv_cyc = 0;
    int n_underrun = 0, n_abort = 0, exp_underrun = 0, exp_abort = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    always @(posedge clk_clk) cyc <= cyc + 1;

    always @(negedge clk_clk) begin
        if (rx_valid === 1'b1) begin
            rx_q.push_back(rx_data);
            last_rxv_cyc = cyc;
        end
        if (tx_underrun === 1'b1) n_underrun++;
        if (frame_abort === 1'b1) n_abort++;
    end

    initial begin
        #5000000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_miso"}, {31'b0, spi_miso}, 0);
        chk({tag, "_miso_oe"}, {31'b0, spi_miso_oe}, 0);
        chk({tag, "_tx_ready"}, {31'b0, tx_ready}, 1);
        chk({tag, "_rx_data"}, {24'b0, rx_data}, 0);
        chk({tag, "_rx_valid"}, {31'b0, rx_valid}, 0);
        chk({tag, "_tx_underrun"}, {31'b0, tx_underrun}, 0);
        chk({tag, "_frame_abort"}, {31'b0, frame_abort}, 0);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
    endtask

    // Offer a word to the holding register; the model queue records it once accepted.
    task automatic tx_push(input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        tx_data  = w;
        tx_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            ok = (tx_ready === 1'b1);
            @(negedge clk_clk);
        end
        tx_valid = 1'b0;
        if (ok) exp_tx.push_back(w);
        else    chk("tx_ready_timeout", {31'b0, tx_ready}, 1);
    endtask

    task automatic ss_start();
        spi_ss_n = 1'b0;
        repeat (2) @(negedge clk_clk);
    endtask

    task automatic ss_stop();
        spi_ss_n = 1'b1;
        repeat (3) @(negedge clk_clk);
        spi_sclk = 1'b0;
        repeat (6) @(negedge clk_clk);
    endtask

    // One frame at clk/8: each frame start takes the oldest queued word, or IDLE_W with an underrun.
    task automatic spi_frame(input logic [7:0] mw, input int nbits, input bit hold_high,
                             input bit do_push, input logic [7:0] pw);
        logic [7:0] got, exp_w;
        if (exp_tx.size() > 0) exp_w = exp_tx.pop_front();
        else begin
            exp_w = IDLE_W;
            exp_underrun++;
        end
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mw[7-i];
            if (do_push && i == 1) begin
                tx_push(pw);
                repeat (3) @(negedge clk_clk);
            end else begin
                repeat (4) @(negedge clk_clk);
            end
            got[7-i] = spi_miso;
            spi_sclk = 1'b1;
            last_rise_cyc = cyc + 1;
            repeat (4) @(negedge clk_clk);
            if (!(hold_high && i == nbits - 1)) spi_sclk = 1'b0;
        end
        if (nbits == DATA_W) begin
            exp_rx.push_back(mw);
            chk("miso_word", {24'b0, got}, {24'b0, exp_w});
        end
    endtask

    task automatic check_rx(input string tag);
        for (int i = 0; i < 64 && rx_q.size() < exp_rx.size(); i++) @(negedge clk_clk);
        repeat (4) @(negedge clk_clk);
        chk({tag, "_rx_count"}, rx_q.size(), exp_rx.size());
        while (exp_rx.size() > 0 && rx_q.size() > 0)
            chk({tag, "_rx_data"}, {24'b0, rx_q.pop_front()}, {24'b0, exp_rx.pop_front()});
        rx_q.delete();
        exp_rx.delete();
        chk({tag, "_underruns"}, n_underrun, exp_underrun);
        chk({tag, "_aborts"}, n_abort, exp_abort);
    endtask

    initial begin
        int words, blen, rise_cyc;
        logic [7:0] m, p;
        bit last_f;

        #1 reset_reset_n = 1'b0;
        repeat (3) @(negedge clk_clk);
        check_reset("reset");
        reset_reset_n = 1'b1;
        repeat (5) @(negedge clk_clk);

        // Preloaded word out, 0x3C in, latency of rx_valid
        tx_push(8'hA5);
        chk("t1_tx_ready_full", {31'b0, tx_ready}, 0);
        ss_start();
        spi_frame(8'h3C, 8, 1'b1, 1'b0, 8'h00);
        rise_cyc = last_rise_cyc;
        chk("t1_tx_ready_empty", {31'b0, tx_ready}, 1);
        chk("t1_busy", {31'b0, busy}, 1);
        chk("t1_miso_oe", {31'b0, spi_miso_oe}, 1);
        ss_stop();
        chk("t1_miso_oe_off", {31'b0, spi_miso_oe}, 0);
        chk("t1_busy_off", {31'b0, busy}, 0);
        check_rx("t1");
        chk("t1_rx_latency", last_rxv_cyc - rise_cyc, SYNC_STAGES + 2);

        // Empty holding register: idle word and one underrun
        ss_start();
        spi_frame(8'h00, 8, 1'b1, 1'b0, 8'h00);
        ss_stop();
        check_rx("t2");

        // Back-to-back frames under one select
        tx_push(8'h11);
        ss_start();
        spi_frame(8'hDE, 8, 1'b0, 1'b1, 8'h22);
        spi_frame(8'hAD, 8, 1'b1, 1'b0, 8'h00);
        ss_stop();
        check_rx("t3");

        // Abort after 5 bits, then a clean frame
        ss_start();
        spi_frame(8'hF0, 5, 1'b1, 1'b0, 8'h00);
        ss_stop();
        exp_abort++;
        chk("t4_miso_oe", {31'b0, spi_miso_oe}, 0);
        check_rx("t4_abort");
        ss_start();
        spi_frame(8'h81, 8, 1'b1, 1'b0, 8'h00);
        ss_stop();
        check_rx("t4_next");

        // Reset in the middle of a frame
        ss_start();
        spi_frame(8'h5A, 3, 1'b1, 1'b0, 8'h00);
        reset_reset_n = 1'b0;
        #1;
        check_reset("t5");
        @(negedge clk_clk);
        spi_ss_n = 1'b1;
        spi_sclk = 1'b0;
        exp_tx.delete();
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (5) @(negedge clk_clk);
        tx_push(8'h5A);
        ss_start();
        spi_frame(8'h5A, 8, 1'b1, 1'b0, 8'h00);
        ss_stop();
        check_rx("t5_after");

        // Random bursts at SCLK = clk/8 with occasional missing TX words
        words = 0;
        while (words < 1000) begin
            blen = $urandom_range(1, 16);
            if (blen > 1000 - words) blen = 1000 - words;
            if (exp_tx.size() == 0 && $urandom_range(0, 7) != 0) tx_push(8'($urandom));
            ss_start();
            for (int k = 0; k < blen; k++) begin
                m = 8'($urandom);
                p = 8'($urandom);
                last_f = (k == blen - 1);
                spi_frame(m, 8, last_f, !last_f && ($urandom_range(0, 7) != 0), p);
            end
            ss_stop();
            check_rx("rand");
            words += blen;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
